regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy scoreboard.
//  Serves decode/issue (reads, busy lookup) and writeback (commits) in the RV32I pipeline.
//  Register 0 is hardwired to zero.
//  Synchronous writes and asynchronous reads; scoreboard tracks in-flight destinations.
// PARAMETERS
//  XLEN       32  data width in bits
//  NUM_REGS   32  architectural registers, power of two >= 2
//  NUM_READ    2  read ports
//  NUM_WRITE   1  write ports, 1..2
//  AW         $clog2(NUM_REGS)  address width, derived, not overridable
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high; clears all state
//  rd_addr    in   NUM_READ*AW     read addresses, port i at [i*AW +: AW]
//  rd_data    out  NUM_READ*XLEN   read data, port i at [i*XLEN +: XLEN]
//  rd_busy    out  NUM_READ        1 = register has an outstanding producer
//  wr_en      in   NUM_WRITE       write enable per port
//  wr_addr    in   NUM_WRITE*AW    write addresses
//  wr_data    in   NUM_WRITE*XLEN  write data
//  iss_en     in   1               issue: mark iss_addr busy
//  iss_addr   in   AW              destination being issued
//  busy_vec   out  NUM_REGS        full scoreboard, bit r = register r busy
// BEHAVIOUR
//  - Reset (async, any time, including mid-write): all registers 0, all busy bits 0.
//    rd_data then reads 0 and rd_busy reads 0 combinationally.
//  - Write: on posedge clk with wr_en[j] and wr_addr[j]!=0, reg[wr_addr[j]] <= wr_data[j].
//    The same edge clears busy[wr_addr[j]].
//  - Writes to address 0 are dropped; they change no data and no busy bit.
//  - Same address on both write ports: higher port index wins the data.
//  - Issue: on posedge clk with iss_en and iss_addr!=0, busy[iss_addr] <= 1.
//    Issue to address 0 is ignored; busy[0] is constant 0.
//  - Issue and write to the same register on the same edge: busy ends 1.
//    The new producer wins; the write data is still stored.
//  - Reads are combinational, latency 0.
//    rd_addr==0 returns 0 with rd_busy=0, regardless of state.
//  - Without bypass, a read of a register written this cycle returns the old value.
//  - Both read ports may address the same register; no port conflicts exist.
//  - busy_vec mirrors the registered scoreboard state; it is never bypassed.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-to-read forwarding on the read ports.
//    A read whose address matches an active nonzero write returns that wr_data
//      (highest matching port), and rd_busy for it reads 0.
//    An iss_en to the same address in the same cycle still forces rd_busy=1.
//  REGFILE_BYPASS_EN undefined: reads and rd_busy show registered state only.
//    Write latency to a reader is 1 cycle.
// STRUCTURE
//  Package regfile_pkg holds:
//    XLEN_DEFAULT=32, NUM_REGS_DEFAULT=32, REG_ZERO=0
//    the function addr_width(n) used to derive AW
//  Sub-module regfile_scoreboard owns the busy bits, issue/clear priority and busy_vec.
//    Ports: clk, reset, iss_en, iss_addr, clr_en[NUM_WRITE], clr_addr.
//  Top level: storage array, write arbitration, read muxes, optional bypass logic.
// TESTING
//  1. Assert reset mid-run after writing x5=0xDEAD_BEEF
//     -> rd_data(x5)=0 and busy_vec=0 immediately, before any clock edge.
//  2. Write x3=0x1234 at edge N, read x3 in the same cycle and after
//     -> old 0 before edge N, 0x1234 after it.
//     With REGFILE_BYPASS_EN: 0x1234 in the write cycle itself.
//  3. Write x0=0xFFFF_FFFF, then issue x0
//     -> rd_data(x0)=0, rd_busy=0, busy_vec[0]=0 on every cycle.
//  4. Issue x7, write x7=0x55 two edges later
//     -> busy_vec[7]=1 for two cycles, then 0 with data 0x55.
//     Issue x7 and write x7 on the same edge -> busy_vec[7] stays 1.
//  5. NUM_WRITE=2: port0 writes x9=0xAAAA, port1 writes x9=0xBBBB on the same edge
//     -> x9 reads 0xBBBB afterwards.
//  6. NUM_READ=4, all ports reading x12=0x77 with one port reading x0
//     -> three ports return 0x77, the x0 port returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int NUM_REGS_DEFAULT = 32;
    localparam int REG_ZERO         = 0;

    function automatic int addr_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS  = NUM_REGS_DEFAULT,
    parameter  int NUM_WRITE = 1,
    localparam int AW        = addr_width(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic [NUM_WRITE-1:0]    clr_en,
    input  logic [NUM_WRITE*AW-1:0] clr_addr,
    output logic [NUM_REGS-1:0]     busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (clr_en[j]) begin
                busy_d[clr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        // A new producer outranks the retiring one on the same edge.
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN      = XLEN_DEFAULT,
    parameter  int NUM_REGS  = NUM_REGS_DEFAULT,
    parameter  int NUM_READ  = 2,
    parameter  int NUM_WRITE = 1,
    localparam int AW        = addr_width(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_READ*AW-1:0]    rd_addr,
    output logic [NUM_READ*XLEN-1:0]  rd_data,
    output logic [NUM_READ-1:0]       rd_busy,
    input  logic [NUM_WRITE-1:0]      wr_en,
    input  logic [NUM_WRITE*AW-1:0]   wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0] wr_data,
    input  logic                      iss_en,
    input  logic [AW-1:0]             iss_addr,
    output logic [NUM_REGS-1:0]       busy_vec
);

    logic [XLEN-1:0]      regs_q [NUM_REGS];
    logic [XLEN-1:0]      regs_d [NUM_REGS];
    logic [NUM_WRITE-1:0] wr_act;
    logic                 iss_act;

    always_comb begin
        wr_act = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            wr_act[j] = wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO));
        end
        iss_act = iss_en && (iss_addr != AW'(REG_ZERO));
    end

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_act[j]) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_act),
        .iss_addr (iss_addr),
        .clr_en   (wr_act),
        .clr_addr (wr_addr),
        .busy_vec (busy_vec)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            logic [AW-1:0] a;
            a = rd_addr[i*AW +: AW];
            if (a != AW'(REG_ZERO)) begin
                rd_data[i*XLEN +: XLEN] = regs_q[a];
                rd_busy[i] = busy_vec[a];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (wr_act[j] && wr_addr[j*AW +: AW] == a) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        rd_busy[i] = 1'b0;
                    end
                end
                if (iss_act && iss_addr == a) begin
                    rd_busy[i] = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with 4 read and 2 write ports.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [NR-1:0]        busy_vec;

    int vectors = 0;
    int miscompares = 0;

    regfile_mp #(
        .XLEN      (XLEN),
        .NUM_REGS  (NR),
        .NUM_READ  (NRD),
        .NUM_WRITE (NWR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] rdd(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic drive_wr(input int p, input logic [AW-1:0] a,
                            input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        wr_addr = '0;
        wr_data = '0;
        iss_addr = '0;
        rd_addr = '0;
        set_rd(0, 5'd5);
        #1;
        vectors++;
        if (rdd(0) !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd: got %h want %h", rdd(0), 32'h0);
        end
        vectors++;
        if (busy_vec !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_busy: got %h want %h", busy_vec, 32'h0);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_async_reset();
        step();
        drive_wr(0, 5'd5, 32'hDEAD_BEEF);
        step();
        idle();
        set_rd(0, 5'd5);
        #1;
        vectors++;
        if (rdd(0) !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL x5_write: got %h want %h", rdd(0), 32'hDEAD_BEEF);
        end
        iss_en = 1'b1;
        iss_addr = 5'd6;
        step();
        idle();
        #1;
        vectors++;
        if (busy_vec !== 32'h0000_0040) begin
            miscompares++;
            $display("FAIL x6_issue: got %h want %h", busy_vec, 32'h40);
        end
        drive_wr(0, 5'd5, 32'h1111_1111);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (rdd(0) !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_rd: got %h want %h", rdd(0), 32'h0);
        end
        vectors++;
        if (busy_vec !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_busy: got %h want %h", busy_vec, 32'h0);
        end
        idle();
        #1 reset = 1'b0;
    endtask

    task automatic test_write_latency();
        step();
        set_rd(0, 5'd3);
        drive_wr(0, 5'd3, 32'h1234);
        #1;
        vectors++;
        if (rdd(0) !== (BYP ? 32'h1234 : 32'h0)) begin
            miscompares++;
            $display("FAIL x3_same_cycle: got %h want %h", rdd(0),
                     BYP ? 32'h1234 : 32'h0);
        end
        vectors++;
        if (rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL x3_busy: got %b want 0", rd_busy[0]);
        end
        step();
        idle();
        #1;
        vectors++;
        if (rdd(0) !== 32'h1234) begin
            miscompares++;
            $display("FAIL x3_after: got %h want %h", rdd(0), 32'h1234);
        end
    endtask

    task automatic test_x0();
        set_rd(0, 5'd0);
        drive_wr(0, 5'd0, 32'hFFFF_FFFF);
        #1;
        vectors++;
        if (rdd(0) !== 32'h0 || rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_wr_cycle: got %h/%b want 0/0", rdd(0), rd_busy[0]);
        end
        step();
        idle();
        iss_en = 1'b1;
        iss_addr = 5'd0;
        #1;
        vectors++;
        if (rdd(0) !== 32'h0 || rd_busy[0] !== 1'b0 || busy_vec[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_iss_cycle: got %h/%b/%b want 0/0/0",
                     rdd(0), rd_busy[0], busy_vec[0]);
        end
        step();
        idle();
        #1;
        vectors++;
        if (rdd(0) !== 32'h0 || rd_busy[0] !== 1'b0 || busy_vec !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_after: got %h/%b/%h want 0/0/0",
                     rdd(0), rd_busy[0], busy_vec);
        end
    endtask

    task automatic test_issue_clear();
        set_rd(1, 5'd7);
        iss_en = 1'b1;
        iss_addr = 5'd7;
        step();
        idle();
        #1;
        vectors++;
        if (busy_vec[7] !== 1'b1 || rd_busy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL x7_busy1: got %b/%b want 1/1", busy_vec[7], rd_busy[1]);
        end
        step();
        vectors++;
        if (busy_vec[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL x7_busy2: got %b want 1", busy_vec[7]);
        end
        drive_wr(0, 5'd7, 32'h55);
        #1;
        vectors++;
        if (rd_busy[1] !== !BYP || busy_vec[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL x7_wb_cycle: got %b/%b want %b/1",
                     rd_busy[1], busy_vec[7], !BYP);
        end
        step();
        idle();
        #1;
        vectors++;
        if (busy_vec[7] !== 1'b0 || rdd(1) !== 32'h55) begin
            miscompares++;
            $display("FAIL x7_retired: got %b/%h want 0/%h", busy_vec[7], rdd(1), 32'h55);
        end
        iss_en = 1'b1;
        iss_addr = 5'd7;
        drive_wr(0, 5'd7, 32'h66);
        #1;
        vectors++;
        if (rd_busy[1] !== BYP) begin
            miscompares++;
            $display("FAIL x7_tie_cycle: got %b want %b", rd_busy[1], BYP);
        end
        step();
        idle();
        #1;
        vectors++;
        if (busy_vec[7] !== 1'b1 || rdd(1) !== 32'h66) begin
            miscompares++;
            $display("FAIL x7_tie: got %b/%h want 1/%h", busy_vec[7], rdd(1), 32'h66);
        end
        drive_wr(0, 5'd7, 32'h66);
        step();
        idle();
        #1;
        vectors++;
        if (busy_vec !== 32'h0) begin
            miscompares++;
            $display("FAIL x7_cleanup: got %h want 0", busy_vec);
        end
    endtask

    task automatic test_dual_write();
        set_rd(2, 5'd9);
        drive_wr(0, 5'd9, 32'hAAAA);
        drive_wr(1, 5'd9, 32'hBBBB);
        #1;
        vectors++;
        if (rdd(2) !== (BYP ? 32'hBBBB : 32'h0)) begin
            miscompares++;
            $display("FAIL x9_cycle: got %h want %h", rdd(2), BYP ? 32'hBBBB : 32'h0);
        end
        step();
        idle();
        #1;
        vectors++;
        if (rdd(2) !== 32'hBBBB) begin
            miscompares++;
            $display("FAIL x9_prio: got %h want %h", rdd(2), 32'hBBBB);
        end
        drive_wr(0, 5'd10, 32'h1);
        drive_wr(1, 5'd11, 32'h2);
        step();
        idle();
        set_rd(0, 5'd10);
        set_rd(1, 5'd11);
        #1;
        vectors++;
        if (rdd(0) !== 32'h1 || rdd(1) !== 32'h2) begin
            miscompares++;
            $display("FAIL x10_x11: got %h/%h want 1/2", rdd(0), rdd(1));
        end
    endtask

    task automatic test_multi_read();
        drive_wr(1, 5'd12, 32'h77);
        step();
        idle();
        set_rd(0, 5'd12);
        set_rd(1, 5'd12);
        set_rd(2, 5'd0);
        set_rd(3, 5'd12);
        #1;
        for (int p = 0; p < NRD; p++) begin
            logic [XLEN-1:0] exp;
            exp = (p == 2) ? 32'h0 : 32'h77;
            vectors++;
            if (rdd(p) !== exp || rd_busy[p] !== 1'b0) begin
                miscompares++;
                $display("FAIL multi_rd%0d: got %h/%b want %h/0", p, rdd(p), rd_busy[p], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_write_latency();
        test_x0();
        test_issue_clear();
        test_dual_write();
        test_multi_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
